// File: rtl/debug_msg_gen_pkg.sv
// Shared types and constants for the debug message generator.
// Holds the word-counter width, FSM state encoding and LFSR polynomial.
package debug_msg_gen_pkg;

   localparam int WORD_COUNTER_SIZE = 8;

   typedef enum logic [1:0] {
      GEN_IDLE = 2'd0,
      GEN_SEND = 2'd1,
      GEN_GAP  = 2'd2
   } gen_state_t;

   // x^32 + x^22 + x^2 + x + 1, x^32 term implied by the shift-out bit
   localparam logic [31:0] LFSR_POLY = 32'h0040_0007;

   function automatic logic [31:0] lfsr_step(input logic [31:0] q);
      return {q[30:0], 1'b0} ^ (q[31] ? LFSR_POLY : 32'h0000_0000);
   endfunction

endpackage

// File: rtl/debug_msg_gen_if.sv
// Avalon-ST style streaming interface: valid/ready handshake with sop/eop framing.
interface avalon_st_if #(
   parameter int DATA_W = 128
);
   logic              valid;
   logic              ready;
   logic              sop;
   logic              eop;
   logic [DATA_W-1:0] data;

   modport master (output valid, output sop, output eop, output data, input ready);
   modport slave  (input valid, input sop, input eop, input data, output ready);
endinterface

// File: rtl/debug_msg_gen_lfsr32.sv
// 32-bit Galois LFSR used as the data source when DEBUG_MSG_GEN_LFSR_EN is defined.
module debug_lfsr32
   import debug_msg_gen_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] seed,
   input  logic        adv,
   output logic [31:0] q
);

   // An all-zero state would lock the LFSR, so a zero seed starts at 1
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= 32'h0000_0000;
      end else if (load) begin
         q <= (seed == 32'h0000_0000) ? 32'h0000_0001 : seed;
      end else if (adv) begin
         q <= lfsr_step(q);
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/debug_msg_gen.sv
// Debug packet source: sop/eop framed packets of a deterministic pattern with ready backpressure.
// Define DEBUG_MSG_GEN_LFSR_EN to replace the incrementing pattern with a replicated 32-bit LFSR.
module debug_msg_gen
   import debug_msg_gen_pkg::*;
#(
   parameter int DATA_W     = 128,
   parameter int IPG_CYCLES = 2,
   parameter int PKT_CNT_W  = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         stop,
   input  logic [WORD_COUNTER_SIZE-1:0] pkt_len,
   input  logic [PKT_CNT_W-1:0]         pkt_count,
   input  logic [DATA_W-1:0]            seed,
   avalon_st_if.master                  msg_out,
   output logic                         busy,
   output logic                         done,
   output logic [PKT_CNT_W-1:0]         pkts_sent
);

   localparam int GAP_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0);
   localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
   localparam logic [WORD_COUNTER_SIZE-1:0] WC_ZERO = WORD_COUNTER_SIZE'(0);
   localparam logic [WORD_COUNTER_SIZE-1:0] WC_ONE  = WORD_COUNTER_SIZE'(1);
   localparam logic [PKT_CNT_W-1:0] PC_ZERO = PKT_CNT_W'(0);
   localparam logic [PKT_CNT_W-1:0] PC_ONE  = PKT_CNT_W'(1);

   gen_state_t                   state_r, state_nxt;
   logic                         valid_r, sop_r, eop_r;
   logic                         busy_r, done_r, stop_seen_r;
   logic [WORD_COUNTER_SIZE-1:0] len_last_r, wcnt_r;
   logic [PKT_CNT_W-1:0]         cnt_r, pkts_sent_r;
   logic [GAP_W-1:0]             gap_r;
   logic                         xfer_s, last_pkt_s;
   logic                         load_s, to_idle_s, gap_start_s, pkt_start_s;

   assign xfer_s     = valid_r & msg_out.ready;
   assign last_pkt_s = stop_seen_r | stop | ((cnt_r != PC_ZERO) && ((pkts_sent_r + PC_ONE) == cnt_r));

   // Next-state and control strobes
   always_comb begin
      state_nxt   = state_r;
      load_s      = 1'b0;
      to_idle_s   = 1'b0;
      gap_start_s = 1'b0;
      pkt_start_s = 1'b0;
      case (state_r)
         GEN_IDLE: begin
            if (start) begin
               state_nxt = GEN_SEND;
               load_s    = 1'b1;
            end else begin
               state_nxt = GEN_IDLE;
            end
         end
         GEN_SEND: begin
            if (xfer_s && eop_r) begin
               if (last_pkt_s) begin
                  state_nxt = GEN_IDLE;
                  to_idle_s = 1'b1;
               end else if (IPG_CYCLES > 0) begin
                  state_nxt   = GEN_GAP;
                  gap_start_s = 1'b1;
               end else begin
                  state_nxt   = GEN_SEND;
                  pkt_start_s = 1'b1;
               end
            end else begin
               state_nxt = GEN_SEND;
            end
         end
         GEN_GAP: begin
            if (gap_r == GAP_LAST) begin
               if (stop_seen_r || stop) begin
                  state_nxt = GEN_IDLE;
                  to_idle_s = 1'b1;
               end else begin
                  state_nxt   = GEN_SEND;
                  pkt_start_s = 1'b1;
               end
            end else begin
               state_nxt = GEN_GAP;
            end
         end
         default: begin
            state_nxt = GEN_IDLE;
            to_idle_s = 1'b1;
         end
      endcase
   end

   // State, framing and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= GEN_IDLE;
         valid_r     <= 1'b0;
         sop_r       <= 1'b0;
         eop_r       <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         stop_seen_r <= 1'b0;
         len_last_r  <= WC_ZERO;
         wcnt_r      <= WC_ZERO;
         cnt_r       <= PC_ZERO;
         pkts_sent_r <= PC_ZERO;
         gap_r       <= GAP_ZERO;
      end else begin
         state_r <= state_nxt;
         busy_r  <= (state_nxt != GEN_IDLE);
         done_r  <= to_idle_s;
         if (load_s) begin
            len_last_r  <= (pkt_len == WC_ZERO) ? WC_ZERO : (pkt_len - WC_ONE);
            cnt_r       <= pkt_count;
            pkts_sent_r <= PC_ZERO;
            stop_seen_r <= 1'b0;
            wcnt_r      <= WC_ZERO;
            gap_r       <= GAP_ZERO;
            valid_r     <= 1'b1;
            sop_r       <= 1'b1;
            eop_r       <= (pkt_len <= WC_ONE);
         end else begin
            if (stop && (state_r != GEN_IDLE)) begin
               stop_seen_r <= 1'b1;
            end
            if (xfer_s) begin
               if (eop_r) begin
                  wcnt_r      <= WC_ZERO;
                  pkts_sent_r <= pkts_sent_r + PC_ONE;
               end else begin
                  wcnt_r <= wcnt_r + WC_ONE;
               end
            end
            if (to_idle_s || gap_start_s) begin
               valid_r <= 1'b0;
               sop_r   <= 1'b0;
               eop_r   <= 1'b0;
            end else if (pkt_start_s) begin
               valid_r <= 1'b1;
               sop_r   <= 1'b1;
               eop_r   <= (len_last_r == WC_ZERO);
            end else if (xfer_s) begin
               sop_r <= 1'b0;
               eop_r <= ((wcnt_r + WC_ONE) == len_last_r);
            end
            if (gap_start_s) begin
               gap_r <= GAP_ZERO;
            end else if (state_r == GEN_GAP) begin
               gap_r <= gap_r + GAP_ONE;
            end
         end
      end
   end

`ifdef DEBUG_MSG_GEN_LFSR_EN
   logic [31:0]       lfsr_q;
   logic [DATA_W-1:0] data_s;

   debug_lfsr32 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (load_s),
      .seed (seed[31:0]),
      .adv  (xfer_s),
      .q    (lfsr_q)
   );

   // Replicate the 32-bit LFSR word across the full data width
   always_comb begin
      data_s = {DATA_W{1'b0}};
      for (int i = 0; i < DATA_W; i++) begin
         data_s[i] = lfsr_q[i % 32];
      end
   end

   assign msg_out.data = data_s;
`else
   logic [DATA_W-1:0] data_r;

   // Incrementing pattern, carried across packet boundaries within a run
   always_ff @(posedge clk) begin
      if (rst) begin
         data_r <= {DATA_W{1'b0}};
      end else if (load_s) begin
         data_r <= seed;
      end else if (xfer_s) begin
         data_r <= data_r + {{(DATA_W-1){1'b0}}, 1'b1};
      end else begin
         data_r <= data_r;
      end
   end

   assign msg_out.data = data_r;
`endif

   assign msg_out.valid = valid_r;
   assign msg_out.sop   = sop_r;
   assign msg_out.eop   = eop_r;
   assign busy          = busy_r;
   assign done          = done_r;
   assign pkts_sent     = pkts_sent_r;

endmodule

// File: tb/tb_debug_msg_gen.sv
// Self-checking bench for debug_msg_gen: table-driven runs, randomized runs and reset sequence,
// all compared against a word-list model built from the framing and data-pattern rules.
module tb_debug_msg_gen;
   import debug_msg_gen_pkg::*;

   localparam int DATA_W = 128;
   localparam int IPG    = 2;
   localparam int PCW    = 16;

   logic                         clk = 1'b0;
   logic                         rst, start, stop;
   logic [WORD_COUNTER_SIZE-1:0] pkt_len;
   logic [PCW-1:0]               pkt_count;
   logic [DATA_W-1:0]            seed;
   logic                         busy, done;
   logic [PCW-1:0]               pkts_sent;

   avalon_st_if #(.DATA_W(DATA_W)) msg ();

   debug_msg_gen #(.DATA_W(DATA_W), .IPG_CYCLES(IPG), .PKT_CNT_W(PCW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .pkt_len   (pkt_len),
      .pkt_count (pkt_count),
      .seed      (seed),
      .msg_out   (msg),
      .busy      (busy),
      .done      (done),
      .pkts_sent (pkts_sent)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               len;
      int               cnt;
      logic [DATA_W-1:0] sd;
      int               rmode;      // 0: ready=1, 1: ready 1,0,0,1..., 2: random
      int               stop_at;    // global word index carrying a stop pulse, -1 none
      bit               poke;       // start with new config mid-run (must be ignored)
      bit               sstop;      // stop together with start
      int               exp_words;  // -1: take from model
      int               exp_pkts;
   } vec_t;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] first_word(input logic [DATA_W-1:0] s);
`ifdef DEBUG_MSG_GEN_LFSR_EN
      logic [31:0] v;
      v = (s[31:0] == 32'h0) ? 32'h1 : s[31:0];
      return {(DATA_W/32){v}};
`else
      return s;
`endif
   endfunction

   function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] x);
`ifdef DEBUG_MSG_GEN_LFSR_EN
      logic [32:0] t;
      t = {x[31:0], 1'b0};
      if (t[32]) t = t ^ 33'h1_0040_0007;
      return {(DATA_W/32){t[31:0]}};
`else
      return x + 128'd1;
`endif
   endfunction

   task automatic run_case(input vec_t v);
      int L, total, k, cyc, gap_len, done_cnt, ew_pk;
      bit in_gap, prev_stall, first, r;
      logic [DATA_W-1:0] ew, hold_d;
      logic hold_s, hold_e;
      L     = (v.len == 0) ? 1 : v.len;
      total = (v.cnt != 0) ? v.cnt * L : ((v.stop_at / L) + 1) * L;
      ew_pk = (v.exp_pkts >= 0) ? v.exp_pkts : total / L;
      k = 0; cyc = 0; gap_len = 0; done_cnt = 0;
      in_gap = 1'b0; prev_stall = 1'b0; first = 1'b1;
      hold_d = '0; hold_s = 1'b0; hold_e = 1'b0;
      ew = first_word(v.sd);
      @(negedge clk);
      pkt_len = WORD_COUNTER_SIZE'(v.len);
      pkt_count = PCW'(v.cnt);
      seed = v.sd;
      start = 1'b1;
      stop = v.sstop;
      msg.ready = 1'b1;
      while (cyc < 3000) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         stop = 1'b0;
         if (first) begin
            check("latency_valid_sop", {msg.valid, msg.sop}, 2'b11);
            check("latency_data", msg.data, ew);
            first = 1'b0;
         end
         if (prev_stall) begin
            check("stall_data", msg.data, hold_d);
            check("stall_ctrl", {msg.valid, msg.sop, msg.eop}, {1'b1, hold_s, hold_e});
         end
         if (done) begin
            done_cnt++;
            break;
         end
         case (v.rmode)
            0: r = 1'b1;
            1: r = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
            default: r = ($urandom_range(0, 3) != 0);
         endcase
         msg.ready = r;
         if (msg.valid) begin
            if (in_gap) begin
               check("gap_len", gap_len, IPG);
               in_gap = 1'b0;
            end
            if (r) begin
               check("word_data", msg.data, ew);
               check("word_sop_eop", {msg.sop, msg.eop}, {(k % L) == 0, (k % L) == (L - 1)});
               if (k == v.stop_at) stop = 1'b1;
               if (v.poke && k == 1) begin
                  start = 1'b1;
                  pkt_len = 7;
                  pkt_count = 9;
                  seed = ~v.sd;
               end
               if (((k % L) == (L - 1)) && (k != total - 1)) begin
                  in_gap = 1'b1;
                  gap_len = 0;
               end
               k++;
               ew = next_word(ew);
               prev_stall = 1'b0;
            end else begin
               prev_stall = 1'b1;
               hold_d = msg.data;
               hold_s = msg.sop;
               hold_e = msg.eop;
            end
         end else begin
            if (in_gap) gap_len++;
            prev_stall = 1'b0;
         end
      end
      check("done_seen", done_cnt, 1);
      check("word_total", k, (v.exp_words >= 0) ? v.exp_words : total);
      check("pkts_sent", pkts_sent, ew_pk);
      check("idle_busy_valid", {busy, msg.valid}, 2'b00);
      @(negedge clk);
      check("done_single", done, 1'b0);
   endtask

   vec_t vecs[10];
   vec_t rv;
   int   rk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{4,   2, 128'h10,       0, -1, 1'b0, 1'b0,   8, 2};
      vecs[1] = '{3,   2, 128'h100,      1, -1, 1'b0, 1'b0,   6, 2};
      vecs[2] = '{0,   3, 128'h5,        0, -1, 1'b0, 1'b0,   3, 3};
      vecs[3] = '{1,   2, {DATA_W{1'b1}}, 2, -1, 1'b0, 1'b0,  2, 2};
      vecs[4] = '{5,   0, 128'h40,       0,  2, 1'b0, 1'b0,   5, 1};
      vecs[5] = '{3,   0, 128'h7,        2,  4, 1'b0, 1'b0,   6, 2};
      vecs[6] = '{2,   2, 128'h30,       0, -1, 1'b0, 1'b1,   4, 2};
      vecs[7] = '{3,   2, 128'h50,       2, -1, 1'b1, 1'b0,   6, 2};
      vecs[8] = '{255, 1, 128'h1000,     0, -1, 1'b0, 1'b0, 255, 1};
      vecs[9] = '{2,   1, 128'h0,        1, -1, 1'b0, 1'b0,   2, 1};

      rst = 1'b1; start = 1'b0; stop = 1'b0;
      pkt_len = '0; pkt_count = '0; seed = '0; msg.ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ctrl", {msg.valid, msg.sop, msg.eop, busy, done}, 5'b00000);
      check("reset_data", msg.data, 128'h0);
      check("reset_pkts_sent", pkts_sent, 16'h0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) run_case(vecs[i]);

      for (int i = 0; i < 8; i++) begin
         rv.len   = $urandom_range(0, 9);
         rv.cnt   = (i < 6) ? $urandom_range(1, 3) : 0;
         rv.sd    = {$urandom, $urandom, $urandom, $urandom};
         rv.rmode = 2;
         rv.stop_at = (i < 6) ? -1 : $urandom_range(0, 3 * ((rv.len == 0) ? 1 : rv.len) - 1);
         rv.poke  = 1'b0;
         rv.sstop = 1'b0;
         rv.exp_words = -1;
         rv.exp_pkts  = -1;
         run_case(rv);
      end

      // Reset on word 2 of the second 6-word packet of a continuous run
      @(negedge clk);
      pkt_len = 6; pkt_count = 0; seed = 128'hABCD; start = 1'b1; msg.ready = 1'b1;
      rk = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (msg.valid) begin
            if (rk == 8) break;
            rk++;
         end
      end
      check("pre_reset_word_idx", rk, 8);
      check("pre_reset_pkts_sent", pkts_sent, 16'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("post_reset_ctrl", {msg.valid, msg.eop, busy, done}, 4'b0000);
      check("post_reset_pkts_sent", pkts_sent, 16'h0);
      rv = '{6, 1, 128'h2222, 0, -1, 1'b0, 1'b0, 6, 1};
      run_case(rv);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
